// File: rtl/mm_pkg.sv
// ----------------------------------------------------------------------------
// mm_pkg
// Shared definitions for the MM_RTL SM2 datapath:
//   - default operand width and CLA cell width
//   - SM2 prime modulus constant
//   - state encoding of the word-serial modular add/sub unit
// ----------------------------------------------------------------------------
package mm_pkg;

    localparam int MM_WIDTH = 256;
    localparam int MM_CELL  = 16;

    localparam logic [255:0] SM2_P =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_PASS2 = 2'd2,
        ST_FIN   = 2'd3
    } addsub_state_e;

endpackage

// File: rtl/mod_addsub_ws_cla_cell.sv
// ----------------------------------------------------------------------------
// CLA_cell
// CELL-bit carry-lookahead adder cell, purely combinational.
// Ports:
//   i_a, i_b  : CELL-bit addends
//   i_cin     : carry in
//   o_sum     : CELL-bit sum
//   o_cout    : carry out
// ----------------------------------------------------------------------------
module CLA_cell #(
    parameter int CELL = 16
) (
    input  logic [CELL-1:0] i_a,
    input  logic [CELL-1:0] i_b,
    input  logic            i_cin,
    output logic [CELL-1:0] o_sum,
    output logic            o_cout
);

    logic [CELL-1:0] w_g;
    logic [CELL-1:0] w_p;
    logic [CELL:0]   w_c;

    // Generate/propagate form; the carry recurrence is flattened into
    // lookahead logic by synthesis.
    always_comb begin
        w_g    = i_a & i_b;
        w_p    = i_a ^ i_b;
        w_c    = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < CELL; i++) begin
            w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
        end
        o_sum  = w_p ^ w_c[CELL-1:0];
        o_cout = w_c[CELL];
    end

endmodule

// File: rtl/mod_addsub_ws.sv
// ----------------------------------------------------------------------------
// mod_addsub_ws
// Word-serial modular adder/subtractor: r = (a +/- b) mod p, streaming CELL-bit
// words through a single CLA_cell, one word per clock. Two passes of N words
// (raw sum, then correction by p) followed by a one-cycle FIN selection.
// Optional feature macro: MOD_ADDSUB_SUB_EN (subtract support). When not
// defined, i_op is treated as 0 and every request is an add.
// Ports:
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_start, i_op      : request (sampled in IDLE), 0 = add / 1 = subtract
//   i_a, i_b, i_p      : operands and modulus, latched with an accepted start
//   o_busy             : high during PASS1/PASS2
//   o_done             : one-cycle pulse in FIN, o_r valid
//   o_r                : result, held until overwritten by the next FIN
//   o_state            : current FSM state (debug visibility)
// Handshake: i_start is a request accepted at any rising edge where the block
// is in IDLE and i_rst is low; it is ignored at all other edges. o_done pulses
// exactly once per accepted request that is not aborted by reset.
// ----------------------------------------------------------------------------
module mod_addsub_ws
    import mm_pkg::*;
#(
    parameter int WIDTH = MM_WIDTH,
    parameter int CELL  = MM_CELL
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_p,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_r,
    output logic [1:0]       o_state
);

    localparam int N    = WIDTH / CELL;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

`ifdef MOD_ADDSUB_SUB_EN
    localparam logic SUB_EN = 1'b1;
`else
    // Subtract is tied off; the constant folds the subtract muxes and the
    // borrow selection out of the netlist.
    localparam logic SUB_EN = 1'b0;
`endif

    addsub_state_e    r_state;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_t;
    logic [WIDTH-1:0] r_r;
    logic             r_op;
    logic             r_c;
    logic             r_c1;

    logic             w_sub;
    logic             w_last;
    logic [CELL-1:0]  w_x;
    logic [CELL-1:0]  w_y;
    logic [CELL-1:0]  w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_s_full;
    logic [WIDTH-1:0] w_t_full;
    logic             w_use_t;

    assign w_sub  = r_op & SUB_EN;
    assign w_last = (r_idx == IDXW'(N - 1));

    // Operand muxes for the shared cell. Word i of each operand is always in
    // the low CELL bits of its shift register.
    always_comb begin
        w_x = '0;
        w_y = '0;
        case (r_state)
            ST_PASS1: begin
                w_x = r_a[CELL-1:0];
                w_y = w_sub ? ~r_b[CELL-1:0] : r_b[CELL-1:0];
            end
            ST_PASS2: begin
                w_x = r_s[CELL-1:0];
                w_y = w_sub ? r_p[CELL-1:0] : ~r_p[CELL-1:0];
            end
            default: ;
        endcase
    end

    CLA_cell #(.CELL(CELL)) u_cla (
        .i_a    (w_x),
        .i_b    (w_y),
        .i_cin  (r_c),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Values as they will stand after the final PASS2 word: s has been rotated
    // back into place, t receives its top word from the cell this cycle.
    assign w_s_full = {r_s[CELL-1:0], r_s[WIDTH-1:CELL]};
    assign w_t_full = {w_sum, r_t[WIDTH-1:CELL]};

    // Add: s >= p when the raw sum overflowed (c1) or s - p did not borrow (c2).
    // Subtract: a borrow in pass 1 (c1 = 0) means p must be added back.
    assign w_use_t = w_sub ? ~r_c1 : (r_c1 | w_cout);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_p     <= '0;
            r_s     <= '0;
            r_t     <= '0;
            r_r     <= '0;
            r_op    <= 1'b0;
            r_c     <= 1'b0;
            r_c1    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_p     <= i_p;
                        r_op    <= i_op;
                        r_c     <= i_op & SUB_EN;
                        r_idx   <= '0;
                        r_state <= ST_PASS1;
                    end
                end
                ST_PASS1: begin
                    r_s <= {w_sum, r_s[WIDTH-1:CELL]};
                    r_a <= r_a >> CELL;
                    r_b <= r_b >> CELL;
                    if (w_last) begin
                        r_c1    <= w_cout;
                        r_c     <= ~w_sub;
                        r_idx   <= '0;
                        r_state <= ST_PASS2;
                    end else begin
                        r_c   <= w_cout;
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_PASS2: begin
                    // s and p rotate so they are intact again after N words.
                    r_s <= w_s_full;
                    r_p <= {r_p[CELL-1:0], r_p[WIDTH-1:CELL]};
                    r_t <= w_t_full;
                    r_c <= w_cout;
                    if (w_last) begin
                        r_r     <= w_use_t ? w_t_full : w_s_full;
                        r_idx   <= '0;
                        r_state <= ST_FIN;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy  = (r_state == ST_PASS1) || (r_state == ST_PASS2);
    assign o_done  = (r_state == ST_FIN);
    assign o_r     = r_r;
    assign o_state = r_state;

endmodule

// File: tb/tb_mod_addsub_ws.sv
// Self-checking bench for mod_addsub_ws with the SM2 prime as modulus.
module tb_mod_addsub_ws;
    import mm_pkg::*;

    localparam int W    = 256;
    localparam int CELL = 16;
    localparam int LAT  = 2 * (W / CELL) + 1;

`ifdef MOD_ADDSUB_SUB_EN
    localparam logic SUB_EN_TB = 1'b1;
    localparam logic [W-1:0] EXP_SUB_1_2 = SM2_P - 256'd1;
    localparam logic [W-1:0] EXP_SUB_5_5 = 256'd0;
`else
    localparam logic SUB_EN_TB = 1'b0;
    localparam logic [W-1:0] EXP_SUB_1_2 = 256'd3;
    localparam logic [W-1:0] EXP_SUB_5_5 = 256'd10;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] p;
    logic         busy;
    logic         done;
    logic [W-1:0] r;
    logic [1:0]   state;

    int n_tests;
    int n_fail;
    int done_cnt;
    int exp_done_cnt;
    logic [W-1:0] exp_q[$];

    mod_addsub_ws #(.WIDTH(W), .CELL(CELL)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_op    (op),
        .i_a     (a),
        .i_b     (b),
        .i_p     (p),
        .o_busy  (busy),
        .o_done  (done),
        .o_r     (r),
        .o_state (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic m_op, input logic [W-1:0] ma,
                                           input logic [W-1:0] mb, input logic [W-1:0] mp);
        logic [W:0] s;
        if (!(m_op & SUB_EN_TB)) begin
            s = {1'b0, ma} + {1'b0, mb};
            if (s >= {1'b0, mp}) s = s - {1'b0, mp};
        end else if (ma >= mb) begin
            s = {1'b0, ma} - {1'b0, mb};
        end else begin
            s = {1'b0, ma} + {1'b0, mp} - {1'b0, mb};
        end
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_below_p();
        logic [W-1:0] x;
        for (int k = 0; k < W / 32; k++) x[k*32 +: 32] = $urandom;
        if (x >= SM2_P) x = x - SM2_P;
        return x;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            check_val("busy_in_fin", {255'd0, busy}, 256'd0);
            if (exp_q.size() == 0) check_val("extra_done", 256'd1, 256'd0);
            else check_val("result", r, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    // Drives a one-cycle start; the accepting edge is the posedge in between.
    task automatic issue(input logic t_op, input logic [W-1:0] t_a, input logic [W-1:0] t_b,
                         input logic [W-1:0] t_exp, input bit push);
        @(negedge clk);
        start = 1'b1;
        op    = t_op;
        a     = t_a;
        b     = t_b;
        p     = SM2_P;
        if (push) begin
            exp_q.push_back(t_exp);
            exp_done_cnt++;
        end
        @(negedge clk);
        start = 1'b0;
        // Scramble inputs to show operands were latched.
        op = ~t_op;
        a  = rand_below_p();
        b  = rand_below_p();
    endtask

    // Called right after issue(): the current negedge is in cycle k+1.
    task automatic wait_done(input bit chk_lat, input bit extra_start);
        int cnt;
        cnt = 1;
        while (!done && cnt < LAT + 20) begin
            if (extra_start && cnt == 5) begin
                start = 1'b1;
                op    = 1'b0;
                a     = 256'd100;
                b     = 256'd200;
            end
            if (cnt == 6) start = 1'b0;
            @(negedge clk);
            cnt++;
        end
        start = 1'b0;
        if (!done) check_val("done_timeout", 256'd1, 256'd0);
        if (chk_lat) check_val("latency", 256'(cnt), 256'(LAT));
        @(negedge clk);
        check_val("done_pulse", {255'd0, done}, 256'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int snap;
        logic ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        n_tests = 0; n_fail = 0; done_cnt = 0; exp_done_cnt = 0;
        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0; p = SM2_P;
        repeat (3) @(negedge clk);
        check_val("rst_busy",  {255'd0, busy}, 256'd0);
        check_val("rst_done",  {255'd0, done}, 256'd0);
        check_val("rst_r",     r, 256'd0);
        check_val("rst_state", {254'd0, state}, {254'd0, ST_IDLE});
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        issue(1'b0, 256'd1, 256'd2, 256'd3, 1'b1);
        check_val("busy_after_start", {255'd0, busy}, 256'd1);
        wait_done(1'b1, 1'b0);
        issue(1'b0, SM2_P - 256'd1, 256'd1, 256'd0, 1'b1);
        wait_done(1'b1, 1'b0);
        issue(1'b0, SM2_P - 256'd1, SM2_P - 256'd1, SM2_P - 256'd2, 1'b1);
        wait_done(1'b1, 1'b0);
        issue(1'b1, 256'd1, 256'd2, EXP_SUB_1_2, 1'b1);
        wait_done(1'b1, 1'b0);
        issue(1'b1, 256'd5, 256'd5, EXP_SUB_5_5, 1'b1);
        wait_done(1'b1, 1'b1);
        repeat (LAT + 5) @(negedge clk);
        check_val("ignored_start", 256'(done_cnt), 256'(exp_done_cnt));

        // Reset mid-operation
        issue(1'b0, 256'd1, 256'd2, 256'd3, 1'b1);
        wait_done(1'b0, 1'b0);
        snap = done_cnt;
        issue(1'b0, 256'd20, 256'd30, 256'd0, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("abort_busy",  {255'd0, busy}, 256'd0);
        check_val("abort_r",     r, 256'd0);
        check_val("abort_state", {254'd0, state}, {254'd0, ST_IDLE});
        repeat (LAT + 5) @(negedge clk);
        check_val("abort_no_done", 256'(done_cnt), 256'(snap));
        issue(1'b0, 256'd7, 256'd8, 256'd15, 1'b1);
        wait_done(1'b1, 1'b0);

        // Reset wins over a simultaneous start
        @(negedge clk);
        rst = 1'b1; start = 1'b1; a = 256'd1; b = 256'd1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check_val("rst_wins_busy", {255'd0, busy}, 256'd0);
        @(negedge clk);
        check_val("rst_wins_state", {254'd0, state}, {254'd0, ST_IDLE});

        // Random regression against the behavioural model
        for (int i = 0; i < 1000; i++) begin
            ro = 1'($urandom_range(0, 1));
            ra = rand_below_p();
            rb = rand_below_p();
            issue(ro, ra, rb, model(ro, ra, rb, SM2_P), 1'b1);
            wait_done(1'b0, 1'b0);
        end

        repeat (5) @(negedge clk);
        check_val("done_count", 256'(done_cnt), 256'(exp_done_cnt));
        check_val("queue_empty", 256'(exp_q.size()), 256'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
